imu_frame_assembler: RTL and testbench
======================================

Name: imu_frame_assembler

Overview:
- Sits directly upstream of the physics core (center/particle instances).
- Collects a 12-byte IMU sample stream from the sensor-interface byte master and packs it into the 96-bit `data` word that the core consumes.
- Publishes a new word only when the core is not mid-step, so `data` is stable for the whole simulation phase.
- Optionally removes the static bias from accel X/Y, measured over the first frames after reset.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles mid-frame before the partial frame is discarded.
- CAL_EN, 1: 1 = bias calibration enabled; 0 = raw pass-through.
- CAL_LOG2, 4: calibration averages 2^CAL_LOG2 frames (range 1..8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_byte  in  8  sensor byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  block can accept a byte.
- hold  in  1  core mid-step; published data must not change.
- data  out  96  packed frame to the physics core.
- data_valid  out  1  one-cycle pulse when data updates.
- frame_count  out  16  published frames, wraps.
- err_count  out  8  timed-out partial frames, saturates at 255.
- calibrated  out  1  bias valid and being applied.

Behaviour:
- Reset (reset=0, async):
  - data=0, data_valid=0, frame_count=0, err_count=0.
  - calibrated=0 (tied 1 when CAL_EN=0).
  - Accumulators, bias and byte index cleared; state IDLE.
  - Any partial frame is dropped.
- States:
  - IDLE: no bytes yet.
  - COLLECT: 1..11 bytes held.
  - PENDING: full frame waiting for hold=0.
- Handshake:
  - Byte accepted on a clk edge where in_valid&&in_ready.
  - in_ready=1 in IDLE/COLLECT, 0 in PENDING (combinational from state).
  - A byte presented while in_ready=0 is not consumed and must be held by the source.
- Packing:
  - Byte k (0..11) goes to word k/2; even k is the high byte.
  - Word i occupies data[95-16*i -: 16].
  - Word layout: 0..2 = gyro x,y,z; 3 = accel x (data[47:32]); 4 = accel y (data[31:16]); 5 = accel z.
- Transitions:
  - IDLE→COLLECT on the first accepted byte.
  - Accepting byte 11 moves to PENDING (from IDLE or COLLECT).
  - PENDING→IDLE on the edge where hold=0. On that edge:
    - data is loaded with the processed frame;
    - data_valid=1 for exactly the following cycle;
    - frame_count increments.
  - Minimum latency: data updates one edge after the last-byte edge.
  - With hold=1, data is held indefinitely.
- Timeout:
  - In COLLECT, a cycle counter clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, the partial frame is discarded, err_count increments (saturating) and the state returns to IDLE.
  - If a byte is accepted on the same edge as the timeout, the acceptance wins and no timeout occurs.
  - The counter does not run in IDLE or PENDING.
- Calibration (CAL_EN=1):
  - While calibrated=0, frames are published raw, and each published frame's accel x/y (signed 16) is added into signed (16+CAL_LOG2)-bit accumulators.
  - On the publish edge of frame 2^CAL_LOG2, bias = sum >>> CAL_LOG2 (arithmetic shift) and calibrated goes to 1 on that same edge. That frame itself is still raw.
  - From then on, accel x/y are published as (raw − bias) computed at 17 bits and saturated to [−32768, 32767].
  - Words 0,1,2,5 are always unmodified.
  - The bias is only cleared by reset.
- frame_count wraps 0xFFFF→0. err_count stays at 255.
- The core samples data only at its phase-0 cycle; this block guarantees no change while hold=1.

Test Plan:
- CAL_EN=0, hold=0, bytes 0x00..0x0B back-to-back → data=96'h000102030405060708090A0B one edge after the last byte; data_valid high exactly 1 cycle; frame_count=1.
- TIMEOUT_CYCLES=8: send 5 bytes, then idle 8 cycles → err_count=1, no data_valid, state IDLE. Then a full frame of bytes 0x00..0x0B → data=96'h000102030405060708090A0B (correct alignment); err_count still 1.
- hold=1, full frame sent, in_valid kept high with 0xAA → in_ready=0 from the cycle after the last byte; data unchanged; 0xAA not consumed. Drop hold → data updates on the next edge; the 0xAA byte is then accepted as byte 0 of the next frame.
- CAL_EN=1, CAL_LOG2=2: 4 frames with accel x=0x0010, accel y=0xFFF0 → published raw, calibrated=1 after the 4th publish. 5th frame with x=0x0018, y=0xFFF0 → data[47:32]=0x0008, data[31:16]=0x0000; gyro and accel z words unchanged.
- Same bias, 6th frame with y=0x7FFF, x=0x8000 → y saturates to 0x7FFF, x saturates to 0x8000.
- reset pulsed low after 6 bytes of a frame → all outputs 0 immediately (async). The next 12 bytes publish as a fresh, correctly aligned frame with frame_count=1.

Source files
------------

// File: rtl/imu_frame_assembler.sv
// Packs a 12-byte IMU sample stream into the 96-bit word consumed by the physics core,
// publishing only while the core is idle and optionally removing static accel X/Y bias.
module imu_frame_assembler #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter bit CAL_EN         = 1'b1,
   parameter int CAL_LOG2       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        hold,
   output logic [95:0] data,
   output logic        data_valid,
   output logic [15:0] frame_count,
   output logic [7:0]  err_count,
   output logic        calibrated
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ACC_W = 16 + CAL_LOG2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, PENDING} state_t;

   state_t state_q, state_d;
   logic [3:0]          byte_idx_q, byte_idx_d;
   logic [95:0]         frame_q, frame_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [95:0]         data_q, data_d;
   logic                valid_q, valid_d;
   logic [15:0]         fcount_q, fcount_d;
   logic [7:0]          err_q, err_d;
   logic [ACC_W-1:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [15:0]         bias_x_q, bias_x_d, bias_y_q, bias_y_d;
   logic                cal_q, cal_d;
   logic [CAL_LOG2-1:0] cal_cnt_q, cal_cnt_d;

   logic        ready, accept, publish, timeout_hit;
   logic [15:0] raw_x, raw_y;
   logic [16:0] diff_x, diff_y;
   logic [ACC_W-1:0] sum_x, sum_y;
   logic [95:0] out_frame;

   function automatic logic [15:0] sat17(input logic [16:0] d);
      if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
      return d[15:0];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, COLLECT: begin
            if (accept)           state_d = (byte_idx_q == 4'd11) ? PENDING : COLLECT;
            else if (timeout_hit) state_d = IDLE;
         end
         PENDING: if (!hold) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A byte arriving on the timeout edge takes priority, so the frame survives.
   always_comb begin
      ready       = (state_q != PENDING);
      accept      = in_valid && ready;
      publish     = (state_q == PENDING) && !hold;
      timeout_hit = (state_q == COLLECT) && !accept && (cnt_q == CNT_LAST);
   end

   always_comb begin
      byte_idx_d = byte_idx_q;
      frame_d    = frame_q;
      cnt_d      = '0;
      if (accept) begin
         byte_idx_d = (byte_idx_q == 4'd11) ? 4'd0 : byte_idx_q + 4'd1;
         for (int k = 0; k < 12; k++)
            if (byte_idx_q == 4'(k)) frame_d[95-8*k -: 8] = in_byte;
      end else if (timeout_hit) begin
         byte_idx_d = 4'd0;
      end else if (state_q == COLLECT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Bias correction is evaluated at 17 bits so extreme inputs clip instead of wrapping.
   always_comb begin
      raw_x     = frame_q[47:32];
      raw_y     = frame_q[31:16];
      diff_x    = {raw_x[15], raw_x} - {bias_x_q[15], bias_x_q};
      diff_y    = {raw_y[15], raw_y} - {bias_y_q[15], bias_y_q};
      sum_x     = acc_x_q + {{CAL_LOG2{raw_x[15]}}, raw_x};
      sum_y     = acc_y_q + {{CAL_LOG2{raw_y[15]}}, raw_y};
      out_frame = frame_q;
      if (CAL_EN && cal_q) begin
         out_frame[47:32] = sat17(diff_x);
         out_frame[31:16] = sat17(diff_y);
      end
   end

   always_comb begin
      data_d    = publish ? out_frame : data_q;
      valid_d   = publish;
      fcount_d  = fcount_q + 16'(publish);
      err_d     = (timeout_hit && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
      acc_x_d   = acc_x_q;
      acc_y_d   = acc_y_q;
      bias_x_d  = bias_x_q;
      bias_y_d  = bias_y_q;
      cal_d     = cal_q;
      cal_cnt_d = cal_cnt_q;
      if (CAL_EN && publish && !cal_q) begin
         acc_x_d   = sum_x;
         acc_y_d   = sum_y;
         cal_cnt_d = cal_cnt_q + CAL_LOG2'(1);
         if (cal_cnt_q == '1) begin
            bias_x_d = sum_x[ACC_W-1:CAL_LOG2];
            bias_y_d = sum_y[ACC_W-1:CAL_LOG2];
            cal_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx_q <= '0;
         frame_q    <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         fcount_q   <= '0;
         err_q      <= '0;
         acc_x_q    <= '0;
         acc_y_q    <= '0;
         bias_x_q   <= '0;
         bias_y_q   <= '0;
         cal_q      <= 1'b0;
         cal_cnt_q  <= '0;
      end else begin
         byte_idx_q <= byte_idx_d;
         frame_q    <= frame_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         fcount_q   <= fcount_d;
         err_q      <= err_d;
         acc_x_q    <= acc_x_d;
         acc_y_q    <= acc_y_d;
         bias_x_q   <= bias_x_d;
         bias_y_q   <= bias_y_d;
         cal_q      <= cal_d;
         cal_cnt_q  <= cal_cnt_d;
      end
   end

   assign in_ready    = ready;
   assign data        = data_q;
   assign data_valid  = valid_q;
   assign frame_count = fcount_q;
   assign err_count   = err_q;
   assign calibrated  = CAL_EN ? cal_q : 1'b1;

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Directed bench: a calibrating instance and a raw pass-through instance share one stimulus stream.
module tb_imu_frame_assembler;

   logic        clk = 1'b0;
   logic        reset, in_valid, hold;
   logic [7:0]  in_byte;
   logic        in_ready, data_valid, calibrated;
   logic [95:0] data;
   logic [15:0] frame_count;
   logic [7:0]  err_count;
   logic        raw_in_ready, raw_data_valid, raw_calibrated;
   logic [95:0] raw_data;
   logic [15:0] raw_frame_count;
   logic [7:0]  raw_err_count;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   imu_frame_assembler #(.TIMEOUT_CYCLES(8), .CAL_EN(1'b1), .CAL_LOG2(2)) dut (
      .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .hold(hold), .data(data), .data_valid(data_valid), .frame_count(frame_count),
      .err_count(err_count), .calibrated(calibrated));

   imu_frame_assembler #(.TIMEOUT_CYCLES(8), .CAL_EN(1'b0), .CAL_LOG2(2)) dut_raw (
      .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(raw_in_ready),
      .hold(hold), .data(raw_data), .data_valid(raw_data_valid), .frame_count(raw_frame_count),
      .err_count(raw_err_count), .calibrated(raw_calibrated));

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = b;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         tests_run++; tests_failed++;
         $display("[TB] FAIL send_byte_wait: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_bytes(input logic [95:0] f, input int first, input int last);
      for (int k = first; k <= last; k++) send_byte(f[95-8*k -: 8]);
   endtask

   task automatic pulse_reset();
      reset = 1'b0; in_valid = 1'b0; hold = 1'b0; in_byte = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; hold = 1'b0; in_byte = 8'h00;
      #2;
      tests_run++;
      if ({data, data_valid, frame_count, err_count} !== 121'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got data=%h dv=%b fc=%h err=%h required all zero", data, data_valid, frame_count, err_count);
      end
      tests_run++;
      if (calibrated !== 1'b0 || raw_calibrated !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_calibrated: got cal=%b raw_cal=%b required 0/1", calibrated, raw_calibrated);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [95:0] f = 96'h000102030405060708090A0B;
      send_bytes(f, 0, 11);
      tests_run++;
      if (in_ready !== 1'b0 || data !== 96'd0) begin
         tests_failed++;
         $display("[TB] FAIL basic_pending: got in_ready=%b data=%h required 0 and 0", in_ready, data);
      end
      @(posedge clk); #1;
      tests_run++;
      if (data !== f || data_valid !== 1'b1 || frame_count !== 16'd1) begin
         tests_failed++;
         $display("[TB] FAIL basic_publish: got data=%h dv=%b fc=%0d required %h 1 1", data, data_valid, frame_count, f);
      end
      tests_run++;
      if (raw_data !== f || raw_data_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL basic_raw_publish: got data=%h dv=%b required %h 1", raw_data, raw_data_valid, f);
      end
      @(posedge clk); #1;
      tests_run++;
      if (data_valid !== 1'b0 || data !== f) begin
         tests_failed++;
         $display("[TB] FAIL basic_pulse_width: got dv=%b data=%h required 0 %h", data_valid, data, f);
      end
   endtask

   task automatic test_timeout();
      logic [95:0] f = 96'h202122232425262728292A2B;
      send_byte(8'h55);
      send_byte(8'h66);
      repeat (7) @(posedge clk);
      send_byte(8'h77);
      tests_run++;
      if (err_count !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_accept_wins: got err=%0d required 0", err_count);
      end
      repeat (7) @(posedge clk);
      #1;
      tests_run++;
      if (err_count !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_early: got err=%0d required 0", err_count);
      end
      @(posedge clk); #1;
      tests_run++;
      if (err_count !== 8'd1 || in_ready !== 1'b1 || frame_count !== 16'd1 || data_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_fire: got err=%0d rdy=%b fc=%0d dv=%b required 1 1 1 0", err_count, in_ready, frame_count, data_valid);
      end
      send_bytes(f, 0, 11);
      @(posedge clk); #1;
      tests_run++;
      if (data !== f || frame_count !== 16'd2 || err_count !== 8'd1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_realign: got data=%h fc=%0d err=%0d required %h 2 1", data, frame_count, err_count, f);
      end
   endtask

   task automatic test_hold();
      logic [95:0] prev = 96'h202122232425262728292A2B;
      logic [95:0] f1   = 96'h303132333435363738393A3B;
      logic [95:0] f2   = 96'hAA0102030405060708090A0B;
      hold = 1'b1;
      send_bytes(f1, 0, 11);
      in_valid = 1'b1;
      in_byte  = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests_run++;
         if (in_ready !== 1'b0 || data !== prev || data_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_stable: got rdy=%b data=%h dv=%b required 0 %h 0", in_ready, data, data_valid, prev);
         end
      end
      tests_run++;
      if (calibrated !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL hold_precal: got cal=%b required 0", calibrated);
      end
      hold = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (data !== f1 || data_valid !== 1'b1 || frame_count !== 16'd3 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL hold_release: got data=%h dv=%b fc=%0d rdy=%b required %h 1 3 1", data, data_valid, frame_count, in_ready, f1);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      send_bytes(f2, 1, 11);
      @(posedge clk); #1;
      tests_run++;
      if (data !== f2 || raw_data !== f2 || frame_count !== 16'd4) begin
         tests_failed++;
         $display("[TB] FAIL hold_held_byte: got data=%h raw=%h fc=%0d required %h 4", data, raw_data, frame_count, f2);
      end
      tests_run++;
      if (calibrated !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL hold_cal_after4: got cal=%b required 1", calibrated);
      end
   endtask

   task automatic test_err_saturate();
      for (int i = 0; i < 253; i++) begin
         send_byte(8'hC3);
         repeat (8) @(posedge clk);
      end
      #1;
      tests_run++;
      if (err_count !== 8'd254 || raw_err_count !== 8'd254) begin
         tests_failed++;
         $display("[TB] FAIL err_count_254: got %0d raw %0d required 254", err_count, raw_err_count);
      end
      for (int i = 0; i < 5; i++) begin
         send_byte(8'hC3);
         repeat (8) @(posedge clk);
      end
      #1;
      tests_run++;
      if (err_count !== 8'd255 || frame_count !== 16'd4) begin
         tests_failed++;
         $display("[TB] FAIL err_count_saturate: got err=%0d fc=%0d required 255 4", err_count, frame_count);
      end
   endtask

   task automatic test_reset_midframe();
      logic [95:0] f = 96'h404142434445464748494A4B;
      send_bytes(f, 0, 5);
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if ({data, data_valid, frame_count, err_count, calibrated} !== 122'd0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL midframe_reset: got data=%h dv=%b fc=%0d err=%0d cal=%b rdy=%b required zeros and rdy 1",
                  data, data_valid, frame_count, err_count, calibrated, in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      send_bytes(f, 0, 11);
      @(posedge clk); #1;
      tests_run++;
      if (data !== f || frame_count !== 16'd1 || err_count !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL midframe_fresh: got data=%h fc=%0d err=%0d required %h 1 0", data, frame_count, err_count, f);
      end
   endtask

   task automatic test_calibration();
      logic [95:0] f_cal = 96'h1111_2222_3333_0010_FFF0_4444;
      logic [95:0] cin [4];
      logic [95:0] cexp[4];
      cin[0] = 96'h1111_2222_3333_0018_FFF0_4444; cexp[0] = 96'h1111_2222_3333_0008_0000_4444;
      cin[1] = 96'h5555_6666_7777_8000_7FFF_8888; cexp[1] = 96'h5555_6666_7777_8000_7FFF_8888;
      cin[2] = 96'h5555_6666_7777_8005_7FF5_8888; cexp[2] = 96'h5555_6666_7777_8000_7FFF_8888;
      cin[3] = 96'h0102_0304_0506_0000_FFE0_0708; cexp[3] = 96'h0102_0304_0506_FFF0_FFF0_0708;
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         send_bytes(f_cal, 0, 11);
         @(posedge clk); #1;
         tests_run++;
         if (data !== f_cal || calibrated !== (i == 3)) begin
            tests_failed++;
            $display("[TB] FAIL cal_learn_%0d: got data=%h cal=%b required %h %b", i, data, calibrated, f_cal, (i == 3));
         end
      end
      for (int i = 0; i < 4; i++) begin
         send_bytes(cin[i], 0, 11);
         @(posedge clk); #1;
         tests_run++;
         if (data !== cexp[i] || data_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cal_apply_%0d: got data=%h dv=%b required %h 1", i, data, data_valid, cexp[i]);
         end
         tests_run++;
         if (raw_data !== cin[i] || raw_calibrated !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cal_raw_%0d: got data=%h cal=%b required %h 1", i, raw_data, raw_calibrated, cin[i]);
         end
      end
      tests_run++;
      if (frame_count !== 16'd8 || calibrated !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL cal_final: got fc=%0d cal=%b required 8 1", frame_count, calibrated);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_hold();
      test_err_saturate();
      test_reset_midframe();
      test_calibration();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
